// File: rtl/mux4_scan_ctrl_pkg.sv
// Shared types and constants for the 4:1 mux scan sequencer.
package mux4_scan_ctrl_pkg;

    localparam int unsigned CH_W   = 2;
    localparam int unsigned NUM_CH = 4;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_PUBLISH = 2'd2
    } state_e;

endpackage

// File: rtl/mux4_next_ch.sv
// Next-set-bit finder: lowest set mask bit (i_first=1) or lowest set bit above i_cur.
module mux4_next_ch
    import mux4_scan_ctrl_pkg::*;
(
    input  logic [NUM_CH-1:0] i_mask,
    input  logic [CH_W-1:0]   i_cur,
    input  logic              i_first,
    output logic [CH_W-1:0]   o_nxt,
    output logic              o_none
);

    always_comb begin
        o_nxt  = '0;
        o_none = 1'b1;
        // Descending scan so the lowest qualifying bit wins.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (i_mask[i] && (i_first || (i > int'(i_cur)))) begin
                o_nxt  = CH_W'(i);
                o_none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/mux4_scan_ctrl.sv
// Scan sequencer: steps mux selects over enabled channels, samples y on the last
// dwell cycle of each channel and publishes the 4-bit frame over valid/ready.
module mux4_scan_ctrl
    import mux4_scan_ctrl_pkg::*;
#(
    parameter int unsigned DWELL_W = 8,
    parameter int unsigned MASK_W  = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_start,
    input  logic               i_stop,
    input  logic               i_continuous,
    input  logic [MASK_W-1:0]  i_mask,
    input  logic [DWELL_W-1:0] i_dwell,
    input  logic               i_y,
    output logic               o_s0,
    output logic               o_s1,
    output logic [MASK_W-1:0]  o_sample,
    output logic               o_sample_valid,
    input  logic               i_sample_ready,
    output logic               o_busy,
    output logic               o_overrun
);

    state_e               r_state, w_state_nxt;
    logic [CH_W-1:0]      r_ch, w_ch_nxt;
    logic [DWELL_W-1:0]   r_cnt, w_cnt_nxt;
    logic [DWELL_W-1:0]   r_dwell, w_dwell_nxt;
    logic [MASK_W-1:0]    r_mask, w_mask_nxt;
    logic [MASK_W-1:0]    r_shadow, w_shadow_nxt;
    logic [MASK_W-1:0]    r_sample, w_sample_nxt;
    logic                 r_cont, w_cont_nxt;
    logic                 r_valid, w_valid_nxt;
    logic                 r_overrun, w_overrun_nxt;

    logic [DWELL_W-1:0]   w_dwell_in;
    logic [NUM_CH-1:0]    w_find_mask;
    logic [CH_W-1:0]      w_found;
    logic                 w_none;
    logic                 w_first;
    logic                 w_free;

    // Only SETTLE advances past the current channel; IDLE and PUBLISH restart from the bottom.
    assign w_find_mask = (r_state == ST_IDLE) ? i_mask : r_mask;
    assign w_first     = (r_state != ST_SETTLE);
    assign w_dwell_in  = (i_dwell == '0) ? DWELL_W'(1) : i_dwell;
    assign w_free      = ~r_valid | i_sample_ready;

    mux4_next_ch u_next_ch (
        .i_mask  (w_find_mask),
        .i_cur   (r_ch),
        .i_first (w_first),
        .o_nxt   (w_found),
        .o_none  (w_none)
    );

    always_comb begin
        w_state_nxt   = r_state;
        w_ch_nxt      = r_ch;
        w_cnt_nxt     = r_cnt;
        w_dwell_nxt   = r_dwell;
        w_mask_nxt    = r_mask;
        w_shadow_nxt  = r_shadow;
        w_sample_nxt  = r_sample;
        w_cont_nxt    = r_cont & ~i_stop;
        w_valid_nxt   = r_valid & ~i_sample_ready;
        w_overrun_nxt = r_overrun | (i_start & (r_state != ST_IDLE));

        unique case (r_state)
            ST_IDLE: begin
                if (i_start && (i_mask != '0)) begin
                    w_mask_nxt   = i_mask;
                    w_dwell_nxt  = w_dwell_in;
                    w_cont_nxt   = i_continuous;
                    w_ch_nxt     = w_found;
                    w_cnt_nxt    = w_dwell_in;
                    w_shadow_nxt = '0;
                    w_state_nxt  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                w_cnt_nxt = r_cnt - DWELL_W'(1);
                if (r_cnt == DWELL_W'(1)) begin
                    w_shadow_nxt[r_ch] = i_y;
                    if (w_none) begin
                        w_state_nxt = ST_PUBLISH;
                    end else begin
                        w_ch_nxt  = w_found;
                        w_cnt_nxt = r_dwell;
                    end
                end
            end
            ST_PUBLISH: begin
                if (w_free) begin
                    w_sample_nxt = r_shadow;
                    w_valid_nxt  = 1'b1;
                    if (w_cont_nxt) begin
                        w_ch_nxt     = w_found;
                        w_cnt_nxt    = r_dwell;
                        w_shadow_nxt = '0;
                        w_state_nxt  = ST_SETTLE;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state   <= ST_IDLE;
            r_ch      <= '0;
            r_cnt     <= '0;
            r_dwell   <= '0;
            r_mask    <= '0;
            r_shadow  <= '0;
            r_sample  <= '0;
            r_cont    <= 1'b0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ch      <= w_ch_nxt;
            r_cnt     <= w_cnt_nxt;
            r_dwell   <= w_dwell_nxt;
            r_mask    <= w_mask_nxt;
            r_shadow  <= w_shadow_nxt;
            r_sample  <= w_sample_nxt;
            r_cont    <= w_cont_nxt;
            r_valid   <= w_valid_nxt;
            r_overrun <= w_overrun_nxt;
        end
    end

    assign o_s0           = r_ch[0];
    assign o_s1           = r_ch[1];
    assign o_sample       = r_sample;
    assign o_sample_valid = r_valid;
    assign o_busy         = (r_state != ST_IDLE);
    assign o_overrun      = r_overrun;

endmodule

// File: tb/tb_mux4_scan_ctrl.sv
// Bench for mux4_scan_ctrl: directed scenarios plus random traffic, checked every
// cycle against a timeline-based reference model of the scan.
module tb_mux4_scan_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic       continuous = 1'b0;
    logic [3:0] mask = 4'h0;
    logic [7:0] dwell = 8'd0;
    logic       sample_ready = 1'b0;
    logic [3:0] d_vec = 4'b1010;
    logic       y;
    logic       s0, s1;
    logic [3:0] sample;
    logic       sample_valid, busy, overrun;
    logic       chk_en = 1'b0;

    int errors = 0;
    int checks = 0;

    // The mux under test: d0..d3 come from d_vec.
    assign y = d_vec[{s1, s0}];

    always #5 clk = ~clk;

    mux4_scan_ctrl #(.DWELL_W(8), .MASK_W(4)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_start        (start),
        .i_stop         (stop),
        .i_continuous   (continuous),
        .i_mask         (mask),
        .i_dwell        (dwell),
        .i_y            (y),
        .o_s0           (s0),
        .o_s1           (s1),
        .o_sample       (sample),
        .o_sample_valid (sample_valid),
        .i_sample_ready (sample_ready),
        .o_busy         (busy),
        .o_overrun      (overrun)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a scan is a list of channels, a dwell D and a cycle count t
    // since start; channel k is sampled when t reaches (k+1)*D.
    bit         m_busy, m_pub, m_cont, m_valid, m_overrun;
    int         m_t, m_d;
    int         m_chs[$];
    logic [3:0] m_shadow, m_sample;
    logic [1:0] m_sel;

    task automatic model_reset();
        m_busy = 0; m_pub = 0; m_cont = 0; m_valid = 0; m_overrun = 0;
        m_t = 0; m_d = 1; m_chs.delete();
        m_shadow = 4'h0; m_sample = 4'h0; m_sel = 2'd0;
    endtask

    task automatic model_begin_scan();
        m_t = 0;
        m_shadow = 4'h0;
        m_sel = 2'(m_chs[0]);
        m_pub = 0;
    endtask

    task automatic model_step();
        bit ld;
        int k;
        ld = 0;
        if (start && m_busy) m_overrun = 1;
        if (!m_busy) begin
            if (start && mask != 4'h0) begin
                m_chs.delete();
                for (int i = 0; i < 4; i++) if (mask[i]) m_chs.push_back(i);
                m_d = (dwell == 8'd0) ? 1 : int'(dwell);
                m_cont = continuous;
                m_busy = 1;
                model_begin_scan();
            end
        end else begin
            if (stop) m_cont = 0;
            if (!m_pub) begin
                m_t++;
                if (m_t % m_d == 0) begin
                    k = m_t / m_d - 1;
                    m_shadow[m_chs[k]] = d_vec[m_chs[k]];
                    if (k == m_chs.size() - 1) m_pub = 1;
                    else m_sel = 2'(m_chs[k + 1]);
                end
            end else if (!m_valid || sample_ready) begin
                m_sample = m_shadow;
                ld = 1;
                if (m_cont) model_begin_scan();
                else m_busy = 0;
            end
        end
        m_valid = ld ? 1'b1 : (m_valid && !sample_ready);
    endtask

    initial begin
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else model_step();
        end
    end

    always @(posedge clk) begin
        #1;
        if (rst_n && chk_en) begin
            chk("model_sel", {s1, s0}, m_sel);
            chk("model_sample", sample, m_sample);
            chk("model_valid", sample_valid, m_valid);
            chk("model_busy", busy, m_busy);
            chk("model_overrun", overrun, m_overrun);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1);
    end

    initial begin
        int n;
        logic [1:0] held;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_sel", {s1, s0}, 2'd0);
        chk("rst_sample", sample, 4'h0);
        chk("rst_valid", sample_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_overrun", overrun, 1'b0);
        rst_n = 1'b1;
        chk_en = 1'b1;
        tick();

        // start with an empty mask is ignored
        mask = 4'h0; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("mask0_busy", busy, 1'b0);
        chk("mask0_overrun", overrun, 1'b0);

        // Single shot, all channels, dwell 3
        mask = 4'hF; dwell = 8'd3; continuous = 1'b0; sample_ready = 1'b1; d_vec = 4'b1010;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t1_sel_e0", {s1, s0}, 2'd0);
        for (int e = 1; e <= 13; e++) begin
            tick();
            if (e == 3) chk("t1_sel_e3", {s1, s0}, 2'd1);
            if (e == 6) chk("t1_sel_e6", {s1, s0}, 2'd2);
            if (e == 9) chk("t1_sel_e9", {s1, s0}, 2'd3);
            if (e == 12) chk("t1_valid_e12", sample_valid, 1'b0);
            if (e == 13) begin
                chk("t1_valid_e13", sample_valid, 1'b1);
                chk("t1_sample", sample, 4'b1010);
                chk("t1_busy_e13", busy, 1'b0);
            end
        end

        // Sparse mask, dwell 0 behaves as 1
        mask = 4'b1010; dwell = 8'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t2_sel_e0", {s1, s0}, 2'd1);
        tick();
        chk("t2_sel_e1", {s1, s0}, 2'd3);
        tick();
        chk("t2_valid_e2", sample_valid, 1'b0);
        tick();
        chk("t2_valid_e3", sample_valid, 1'b1);
        chk("t2_sample", sample, 4'b1010);

        // Continuous with downstream stalled, then back-to-back release
        mask = 4'hF; dwell = 8'd2; continuous = 1'b1; sample_ready = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int e = 1; e <= 20; e++) begin
            tick();
            if (sample_valid) chk("t3_held_sample", sample, 4'b1010);
        end
        chk("t3_stall_valid", sample_valid, 1'b1);
        chk("t3_stall_busy", busy, 1'b1);
        sample_ready = 1'b1;
        tick();
        chk("t3_b2b_valid", sample_valid, 1'b1);
        chk("t3_b2b_sample", sample, 4'b1010);
        tick();
        chk("t3_drained_valid", sample_valid, 1'b0);

        // stop mid-frame: in-flight frame still publishes, then idle
        stop = 1'b1;
        tick();
        stop = 1'b0;
        n = 0;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (sample_valid) n++;
            if (!busy) break;
        end
        chk("t4_frames_after_stop", n, 1);
        chk("t4_idle_after_stop", busy, 1'b0);
        held = {s1, s0};
        repeat (5) tick();
        chk("t4_sel_held", {s1, s0}, held);

        // start while busy sets sticky overrun without disturbing the frame
        continuous = 1'b0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t5_overrun", overrun, 1'b1);
        n = 0;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (sample_valid) begin
                n++;
                chk("t5_sample", sample, 4'b1010);
            end
            if (!busy) break;
        end
        chk("t5_frames", n, 1);
        chk("t5_overrun_sticky", overrun, 1'b1);

        // Asynchronous reset between edges mid-SETTLE
        dwell = 8'd3;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_rst_sel", {s1, s0}, 2'd0);
        chk("t6_rst_valid", sample_valid, 1'b0);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_overrun", overrun, 1'b0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        d_vec = 4'b0110; dwell = 8'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        for (int e = 0; e < 40; e++) begin
            tick();
            if (sample_valid) begin
                n++;
                chk("t6_clean_sample", sample, 4'b0110);
            end
            if (!busy) break;
        end
        chk("t6_clean_frames", n, 1);

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            start        = ($urandom_range(0, 9) == 0);
            stop         = ($urandom_range(0, 24) == 0);
            continuous   = 1'($urandom_range(0, 1));
            mask         = 4'($urandom_range(0, 15));
            dwell        = 8'($urandom_range(0, 3));
            sample_ready = ($urandom_range(0, 3) != 0);
            d_vec        = 4'($urandom_range(0, 15));
            tick();
        end
        start = 1'b0;
        stop = 1'b1;
        sample_ready = 1'b1;
        for (int e = 0; e < 100; e++) begin
            tick();
            if (!busy) break;
        end
        chk("rand_drain_idle", busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
